// File: rtl/hazard3_instr_compress_if.sv
// hazard3_instr_compress_if: instruction-in / packed-word-out streams.
// Both valid/ready handshakes plus the flush request.
interface hazard3_instr_compress_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        in_flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;

   modport master (
      output in_valid, in_instr, in_flush, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_instr, in_flush, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/hazard3_instr_compress.sv
// hazard3_instr_compress: RV32I -> RVC compressor with halfword packer.
// Define HAZARD3_COMPRESS_SP_EN to also emit the SP-relative forms.
module hazard3_instr_compress #(
   parameter int W_STAT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   hazard3_instr_compress_if.slave bus,
   output logic [W_STAT-1:0]       stat_compressed
);

   localparam logic [6:0] OP_IMM = 7'h13;
   localparam logic [6:0] OP     = 7'h33;
   localparam logic [6:0] LUI    = 7'h37;
   localparam logic [6:0] LOAD   = 7'h03;
   localparam logic [6:0] STORE  = 7'h23;
   localparam logic [6:0] JAL    = 7'h6f;
   localparam logic [6:0] JALR   = 7'h67;
   localparam logic [6:0] BRANCH = 7'h63;

   typedef enum logic {EMPTY, HALF} state_t;

   logic [31:0] i;
   logic [6:0]  op, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [20:1] jo;
   logic [12:1] bo;
   logic [1:0]  alu2;
   logic        imm6_ok, rd_c, rs1_c, rs2_c;
   logic        is16;
   logic [15:0] c16;

   assign i       = bus.in_instr;
   assign op      = i[6:0];
   assign rd      = i[11:7];
   assign f3      = i[14:12];
   assign rs1     = i[19:15];
   assign rs2     = i[24:20];
   assign f7      = i[31:25];
   assign jo      = {i[31], i[19:12], i[20], i[30:21]};
   assign bo      = {i[31], i[7], i[30:25], i[11:8]};
   assign imm6_ok = (f7 == 7'h00) || (f7 == 7'h7f);
   assign rd_c    = rd[4:3] == 2'b01;
   assign rs1_c   = rs1[4:3] == 2'b01;
   assign rs2_c   = rs2[4:3] == 2'b01;
   assign alu2    = f3[2] ? {f3[1], f3[0] | ~f3[1]} : 2'b00;

   // Top-down priority: first matching form wins.
   always_comb begin
      is16 = 1'b1;
      c16  = 16'h0000;
      if (i == 32'h0000_0013)
         c16 = 16'h0001;
      else if (op == OP_IMM && f3 == 3'b000 && rd == rs1
               && rs1 != 5'd0 && imm6_ok && i[25:20] != 6'd0)
         c16 = {3'b000, i[25], rd, i[24:20], 2'b01};
      else if (op == OP_IMM && f3 == 3'b000 && rs1 == 5'd0
               && rd != 5'd0 && imm6_ok)
         c16 = {3'b010, i[25], rd, i[24:20], 2'b01};
      else if (op == LUI && rd != 5'd0 && rd != 5'd2
               && (i[31:17] == '0 || i[31:17] == '1)
               && i[17:12] != 6'd0)
         c16 = {3'b011, i[17], rd, i[16:12], 2'b01};
      else if (op == OP_IMM && f3 == 3'b001 && f7 == 7'h00
               && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
         c16 = {4'b0000, rd, rs2, 2'b10};
      else if (op == OP_IMM && f3 == 3'b101
               && (f7 == 7'h00 || f7 == 7'h20)
               && rd == rs1 && rd_c && rs2 != 5'd0)
         c16 = {5'b10000, i[30], rd[2:0], rs2, 2'b01};
      else if (op == OP_IMM && f3 == 3'b111 && rd == rs1
               && rd_c && imm6_ok)
         c16 = {3'b100, i[25], 2'b10, rd[2:0], i[24:20], 2'b01};
      else if (op == OP && rd == rs1 && rd_c && rs2_c
               && ((f7 == 7'h20 && f3 == 3'b000)
                   || (f7 == 7'h00 && f3[2]
                       && f3 != 3'b101)))
         c16 = {6'b100011, rd[2:0], alu2, rs2[2:0], 2'b01};
      else if (op == OP && f3 == 3'b000 && f7 == 7'h00
               && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
         c16 = {4'b1001, rd, rs2, 2'b10};
      else if (op == OP && f3 == 3'b000 && f7 == 7'h00
               && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0)
         c16 = {4'b1000, rd, rs2, 2'b10};
      else if (op == LOAD && f3 == 3'b010 && rd_c && rs1_c
               && i[31:27] == 5'd0 && i[21:20] == 2'd0)
         c16 = {3'b010, i[25:23], rs1[2:0], i[22], i[26],
                rd[2:0], 2'b00};
      else if (op == STORE && f3 == 3'b010 && rs1_c && rs2_c
               && i[31:27] == 5'd0 && i[8:7] == 2'd0)
         c16 = {3'b110, i[25], i[11:10], rs1[2:0], i[9], i[26],
                rs2[2:0], 2'b00};
      else if (op == JAL && rd[4:1] == 4'd0
               && (jo[20:11] == '0 || jo[20:11] == '1))
         c16 = {~rd[0], 2'b01, jo[11], jo[4], jo[9:8], jo[10],
                jo[6], jo[7], jo[3:1], jo[5], 2'b01};
      else if (op == JALR && f3 == 3'b000 && rd[4:1] == 4'd0
               && rs1 != 5'd0 && i[31:20] == 12'd0)
         c16 = {3'b100, rd[0], rs1, 5'd0, 2'b10};
      else if (op == BRANCH && f3[2:1] == 2'b00 && rs2 == 5'd0
               && rs1_c && (bo[12:8] == '0 || bo[12:8] == '1))
         c16 = {2'b11, f3[0], bo[8], bo[4:3], rs1[2:0], bo[7:6],
                bo[2:1], bo[5], 2'b01};
      else if (i == 32'h0010_0073)
         c16 = 16'h9002;
`ifdef HAZARD3_COMPRESS_SP_EN
      else if (op == LOAD && f3 == 3'b010 && rs1 == 5'd2
               && rd != 5'd0 && i[31:28] == 4'd0
               && i[21:20] == 2'd0)
         c16 = {3'b010, i[25], rd, i[24:22], i[27:26], 2'b10};
      else if (op == STORE && f3 == 3'b010 && rs1 == 5'd2
               && i[31:28] == 4'd0 && i[8:7] == 2'd0)
         c16 = {3'b110, i[25], i[11:9], i[27:26], rs2, 2'b10};
      else if (op == OP_IMM && f3 == 3'b000 && rs1 == 5'd2
               && rd_c && i[31:30] == 2'd0 && i[21:20] == 2'd0
               && i[29:22] != 8'd0)
         c16 = {3'b000, i[25:24], i[29:26], i[22], i[23],
                rd[2:0], 2'b00};
      else if (op == OP_IMM && f3 == 3'b000 && rd == 5'd2
               && rs1 == 5'd2 && i[23:20] == 4'd0
               && (i[31:29] == 3'd0 || i[31:29] == 3'd7)
               && i[29:24] != 6'd0)
         c16 = {3'b011, i[29], 5'd2, i[24], i[26], i[28:27],
                i[25], 2'b01};
`endif
      else
         is16 = 1'b0;
   end

   state_t      state, state_nxt;
   logic [15:0] pend, pend_nxt;
   logic        ov_nxt, ol_nxt, accept, flush;
   logic [31:0] od_nxt;

   assign bus.in_ready = !bus.out_valid | bus.out_ready;
   assign accept = bus.in_valid & bus.in_ready;
   assign flush  = !bus.in_valid & bus.in_ready & bus.in_flush
                 & (state == HALF);

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      ov_nxt    = bus.out_valid;
      od_nxt    = bus.out_data;
      ol_nxt    = bus.out_last;
      if (bus.in_ready)
         ov_nxt = 1'b0;
      if (accept) begin
         ol_nxt = 1'b0;
         unique case (state)
            EMPTY: begin
               if (is16) begin
                  pend_nxt  = c16;
                  state_nxt = HALF;
               end else begin
                  ov_nxt = 1'b1;
                  od_nxt = i;
               end
            end
            HALF: begin
               ov_nxt = 1'b1;
               if (is16) begin
                  od_nxt    = {c16, pend};
                  state_nxt = EMPTY;
               end else begin
                  od_nxt   = {i[15:0], pend};
                  pend_nxt = i[31:16];
               end
            end
            default: ;
         endcase
      end else if (flush) begin
         ov_nxt    = 1'b1;
         od_nxt    = {16'h0001, pend};
         ol_nxt    = 1'b1;
         state_nxt = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= EMPTY;
         pend            <= 16'h0000;
         bus.out_valid   <= 1'b0;
         bus.out_data    <= 32'h0;
         bus.out_last    <= 1'b0;
         stat_compressed <= '0;
      end else begin
         state         <= state_nxt;
         pend          <= pend_nxt;
         bus.out_valid <= ov_nxt;
         bus.out_data  <= od_nxt;
         bus.out_last  <= ol_nxt;
         if (accept && is16 && !(&stat_compressed))
            stat_compressed <= stat_compressed + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard3_instr_compress.sv
// tb_hazard3_instr_compress: directed vectors with a halfword-queue
// packing model and a per-cycle output comparator.
module tb_hazard3_instr_compress;

   localparam int TW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [TW-1:0] stat;

   always #5 clk = ~clk;

   hazard3_instr_compress_if bus();

   hazard3_instr_compress #(.W_STAT(TW)) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .stat_compressed (stat)
   );

   typedef struct packed {
      logic [31:0] w;
      logic        l;
   } word_t;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] exp;
      logic        c;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [31:0] cur_exp = 32'h0;
   logic        cur16 = 1'b0;
   logic [15:0] hq[$];
   word_t       exq[$];
   word_t       got[$];
   int          cnt = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = 32'h0;
   vec_t        vt[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   function automatic word_t gw(input int k);
      word_t z;
      z = '0;
      if (got.size() > k)
         z = got[got.size() - 1 - k];
      return z;
   endfunction

   // Model: halfwords queue up in stream order, words pop in pairs.
   always @(negedge clk) begin
      word_t e;
      chk("in_ready", 32'(bus.in_ready),
          32'(!bus.out_valid | bus.out_ready));
      chk("stat", 32'(stat), cnt);
      if (prev_stall) begin
         chk("stall_valid", 32'(bus.out_valid), 1);
         chk("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
         if (exq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_word got %h want none",
                     bus.out_data);
         end else begin
            e = exq.pop_front();
            chk("out_data", bus.out_data, e.w);
            chk("out_last", 32'(bus.out_last), 32'(e.l));
         end
         e.w = bus.out_data;
         e.l = bus.out_last;
         got.push_back(e);
      end
      prev_stall = bus.out_valid & !bus.out_ready;
      prev_data  = bus.out_data;
      if (rst) begin
         hq.delete();
         exq.delete();
         cnt = 0;
         prev_stall = 1'b0;
      end else if (bus.in_valid && bus.in_ready) begin
         hq.push_back(cur_exp[15:0]);
         if (cur16) begin
            if (cnt < (1 << TW) - 1)
               cnt++;
         end else begin
            hq.push_back(cur_exp[31:16]);
         end
         while (hq.size() >= 2) begin
            e.w = {hq[1], hq[0]};
            e.l = 1'b0;
            exq.push_back(e);
            void'(hq.pop_front());
            void'(hq.pop_front());
         end
      end else if (bus.in_flush && bus.in_ready && hq.size() == 1) begin
         e.w = {16'h0001, hq[0]};
         e.l = 1'b1;
         exq.push_back(e);
         hq.delete();
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic put(input logic [31:0] ins, input logic [31:0] exp,
                      input logic c);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      cur_exp = exp;
      cur16 = c;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL put_timeout got in_ready 0 want 1 instr %h", ins);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic do_flush(input int n);
      bus.in_flush = 1'b1;
      idle(n);
      bus.in_flush = 1'b0;
   endtask

   task automatic addv(input logic [31:0] ins, input logic [31:0] exp,
                       input logic c);
      vec_t v;
      v.ins = ins;
      v.exp = exp;
      v.c = c;
      vt.push_back(v);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      int n0;
      word_t a;
      word_t b;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.in_flush  = 1'b0;
      bus.out_ready = 1'b1;

      addv(32'h00000013, 32'h0001, 1);
      addv(32'h00140413, 32'h0405, 1);
      addv(32'hFE008093, 32'h1081, 1);
      addv(32'h02008093, 32'h02008093, 0);
      addv(32'h00008093, 32'h00008093, 0);
      addv(32'h01F00293, 32'h42FD, 1);
      addv(32'hFFF00293, 32'h52FD, 1);
      addv(32'h000011B7, 32'h6185, 1);
      addv(32'hFFFE01B7, 32'h7181, 1);
      addv(32'h00001137, 32'h00001137, 0);
      addv(32'h000201B7, 32'h000201B7, 0);
      addv(32'h00351513, 32'h050E, 1);
      addv(32'h0044D493, 32'h8091, 1);
      addv(32'h4044D493, 32'h8491, 1);
      addv(32'h0040D093, 32'h0040D093, 0);
      addv(32'hFE07F793, 32'h9B81, 1);
      addv(32'h40940433, 32'h8C05, 1);
      addv(32'h00F77733, 32'h8F7D, 1);
      addv(32'h002080B3, 32'h908A, 1);
      addv(32'h006002B3, 32'h829A, 1);
      addv(32'h007302B3, 32'h007302B3, 0);
      addv(32'h00442483, 32'h4044, 1);
      addv(32'h06942E23, 32'hDC64, 1);
      addv(32'h08042483, 32'h08042483, 0);
      addv(32'h801FF06F, 32'hB001, 1);
      addv(32'h7FE000EF, 32'h2FFD, 1);
      addv(32'h0010006F, 32'h0010006F, 0);
      addv(32'h00008067, 32'h8082, 1);
      addv(32'h000280E7, 32'h9282, 1);
      addv(32'h00408067, 32'h00408067, 0);
      addv(32'hF00400E3, 32'hD001, 1);
      addv(32'h0E049F63, 32'hECFD, 1);
      addv(32'h10040063, 32'h10040063, 0);
      addv(32'h00100073, 32'h9002, 1);
      addv(32'h023100B3, 32'h023100B3, 0);
      addv(32'h00140410, 32'h00140410, 0);
`ifdef HAZARD3_COMPRESS_SP_EN
      addv(32'h0FC12083, 32'h50FE, 1);
      addv(32'h00112423, 32'hC406, 1);
      addv(32'h01010413, 32'h0800, 1);
`else
      addv(32'h0FC12083, 32'h0FC12083, 0);
      addv(32'h00112423, 32'h00112423, 0);
      addv(32'h01010413, 32'h01010413, 0);
`endif

      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", bus.out_data, 32'h0);
      chk("rst_out_last", 32'(bus.out_last), 0);
      chk("rst_stat", 32'(stat), 0);
      @(posedge clk);
      #1;

      put(32'h00140413, 32'h0405, 1);
      put(32'h00140413, 32'h0405, 1);
      idle(2);
      chk("pair_word", gw(0).w, 32'h04050405);
      chk("pair_stat", 32'(stat), 2);

      n0 = got.size();
      put(32'h00442483, 32'h4044, 1);
      do_flush(4);
      idle(2);
      chk("flush_count", got.size() - n0, 1);
      chk("flush_word", gw(0).w, 32'h00014044);
      chk("flush_last", 32'(gw(0).l), 1);

      put(32'h00140413, 32'h0405, 1);
      put(32'h023100B3, 32'h023100B3, 0);
      put(32'h00140413, 32'h0405, 1);
      idle(2);
      chk("mix_word0", gw(1).w, 32'h00B30405);
      chk("mix_word1", gw(0).w, 32'h04050231);
      chk("mix_last", 32'(gw(0).l), 0);

      bus.out_ready = 1'b0;
      put(32'h023100B3, 32'h023100B3, 0);
      fork
         put(32'h12345678, 32'h12345678, 0);
         begin
            repeat (5) begin
               @(negedge clk);
               chk("hold_ready", 32'(bus.in_ready), 0);
               chk("hold_data", bus.out_data, 32'h023100B3);
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      idle(3);
      a = gw(1);
      b = gw(0);
      chk("stall_w0", a.w, 32'h023100B3);
      chk("stall_w1", b.w, 32'h12345678);

      foreach (vt[k])
         put(vt[k].ins, vt[k].exp, vt[k].c);
      do_flush(2);
      idle(2);
      chk("stat_sat", 32'(stat), 32'hF);

`ifdef HAZARD3_COMPRESS_SP_EN
      put(32'hFC010113, 32'h7139, 1);
      do_flush(2);
      idle(2);
      chk("sp_word", gw(0).w, 32'h00017139);
      chk("sp_last", 32'(gw(0).l), 1);
`else
      put(32'hFC010113, 32'hFC010113, 0);
      do_flush(2);
      idle(2);
      chk("sp_word", gw(0).w, 32'hFC010113);
      chk("sp_last", 32'(gw(0).l), 0);
`endif

      put(32'h00140413, 32'h0405, 1);
      n0 = got.size();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      do_flush(3);
      idle(2);
      chk("rst_half_count", got.size() - n0, 0);
      chk("rst_half_valid", 32'(bus.out_valid), 0);
      chk("rst_half_stat", 32'(stat), 0);
      chk("drained", exq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
